// File: rtl/anita_trig_pkg.sv
// Shared constants and types for the ANITA L2 coincidence trigger:
// logic-mode codes, ring bit offsets within a sector, L2 FSM state type.
package anita_trig_pkg;

    localparam logic [1:0] MODE_ANY = 2'd0;
    localparam logic [1:0] MODE_TOP = 2'd1;
    localparam logic [1:0] MODE_ALL = 2'd2;
    localparam logic [1:0] MODE_OFF = 2'd3;

    localparam int BOT = 0;
    localparam int MID = 1;
    localparam int TOP = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } l2_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/anita_l2_sector.sv
// One phi sector of the L2 engine: ring windows, hit logic, L2 FSM, count.
// Ports: clk_i, rst_n_i; top_i/mid_i/bot_i registered L1; mode_i registered
// mode; l2_o trigger, l2_flag_o fire pulse, l2_count_o (ANITA_L2_COUNT_EN).
module anita_l2_sector
    import anita_trig_pkg::*;
#(
    parameter int MID_TOP_WIN = 2,
    parameter int BOT_TOP_WIN = 3,
    parameter int BOT_MID_WIN = 1,
    parameter int L2_HOLD     = 3,
    parameter int HOLDOFF     = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        top_i,
    input  logic        mid_i,
    input  logic        bot_i,
    input  logic [1:0]  mode_i,
    output logic        l2_o,
    output logic        l2_flag_o,
    output logic [15:0] l2_count_o
);

    localparam int WMAX = max3(MID_TOP_WIN, BOT_TOP_WIN, BOT_MID_WIN);
    localparam int CW   = $clog2(WMAX + 2);
    localparam int HMAX = max3(L2_HOLD, HOLDOFF, 1);
    localparam int HW   = $clog2(HMAX + 1);

    logic [CW-1:0] mt_q, mt_d;
    logic [CW-1:0] bt_q, bt_d;
    logic [CW-1:0] bmm_q, bmm_d;
    logic [CW-1:0] bmb_q, bmb_d;

    logic          mid_act, bot_act, bmm_act, bmb_act;
    logic          top_mid, top_bot, bot_mid;
    logic          hit_d, hit_q;

    l2_state_e     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          flag_q, flag_d;

    // The pulse cycle itself (l1 high) is the first window cycle, so the
    // counter only has to cover the remaining WIN cycles after it.
    function automatic logic [CW-1:0] win_next(
        input logic          pulse,
        input logic [CW-1:0] cnt,
        input int            len
    );
        if (pulse) begin
            return CW'(len);
        end else if (cnt != '0) begin
            return cnt - CW'(1);
        end
        return cnt;
    endfunction

    always_comb begin
        mt_d  = win_next(mid_i, mt_q, MID_TOP_WIN);
        bt_d  = win_next(bot_i, bt_q, BOT_TOP_WIN);
        bmm_d = win_next(mid_i, bmm_q, BOT_MID_WIN);
        bmb_d = win_next(bot_i, bmb_q, BOT_MID_WIN);
    end

    assign mid_act = mid_i | (mt_q != '0);
    assign bot_act = bot_i | (bt_q != '0);
    assign bmm_act = mid_i | (bmm_q != '0);
    assign bmb_act = bot_i | (bmb_q != '0);

    assign top_mid = top_i & mid_act;
    assign top_bot = top_i & bot_act;
    assign bot_mid = (mid_i & bmb_act) | (bot_i & bmm_act);

    always_comb begin
        hit_d = 1'b0;
        unique case (mode_i)
            MODE_ANY: hit_d = top_mid | top_bot | bot_mid;
            MODE_TOP: hit_d = top_mid | top_bot;
            MODE_ALL: hit_d = top_i & mid_act & bot_act;
            MODE_OFF: hit_d = 1'b0;
        endcase
    end

    // A hit seen on the last holdoff cycle is taken directly, so a
    // continuous hit repeats with period L2_HOLD + HOLDOFF.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        flag_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit_q) begin
                    state_d = ST_FIRE;
                    hold_d  = HW'(L2_HOLD);
                    flag_d  = 1'b1;
                end
            end
            ST_FIRE: begin
                if (hold_q == HW'(1)) begin
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_HOLDOFF;
                        hold_d  = HW'(HOLDOFF);
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == HW'(1)) begin
                    if (hit_q) begin
                        state_d = ST_FIRE;
                        hold_d  = HW'(L2_HOLD);
                        flag_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mt_q    <= '0;
            bt_q    <= '0;
            bmm_q   <= '0;
            bmb_q   <= '0;
            hit_q   <= 1'b0;
            state_q <= ST_IDLE;
            hold_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            mt_q    <= mt_d;
            bt_q    <= bt_d;
            bmm_q   <= bmm_d;
            bmb_q   <= bmb_d;
            hit_q   <= hit_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            flag_q  <= flag_d;
        end
    end

    assign l2_o      = (state_q == ST_FIRE);
    assign l2_flag_o = flag_q;

`ifdef ANITA_L2_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (flag_q && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign l2_count_o = count_q;
`else
    assign l2_count_o = '0;
`endif

endmodule

// File: rtl/anita_l2_coinc_engine.sv
// NPHI-sector L2 coincidence engine: mask/force, stage-1 registers, sectors.
// Ports: l1_top/mid/bot_i pulses, mask_i/force_i/mode_i config, l2_o,
// l1_flag_o, l2_flag_o, l2_count_o (built only with ANITA_L2_COUNT_EN).
module anita_l2_coinc_engine
    import anita_trig_pkg::*;
#(
    parameter int NPHI        = 2,
    parameter int MID_TOP_WIN = 2,
    parameter int BOT_TOP_WIN = 3,
    parameter int BOT_MID_WIN = 1,
    parameter int L2_HOLD     = 3,
    parameter int HOLDOFF     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NPHI-1:0]      l1_top_i,
    input  logic [NPHI-1:0]      l1_mid_i,
    input  logic [NPHI-1:0]      l1_bot_i,
    input  logic [3*NPHI-1:0]    mask_i,
    input  logic [3*NPHI-1:0]    force_i,
    input  logic [1:0]           mode_i,
    output logic [NPHI-1:0]      l2_o,
    output logic [3*NPHI-1:0]    l1_flag_o,
    output logic [NPHI-1:0]      l2_flag_o,
    output logic [16*NPHI-1:0]   l2_count_o
);

    logic [3*NPHI-1:0] raw;
    logic [3*NPHI-1:0] l1_d, l1_q;
    logic [1:0]        mode_q;

    always_comb begin
        raw = '0;
        for (int p = 0; p < NPHI; p++) begin
            raw[3*p+BOT] = l1_bot_i[p];
            raw[3*p+MID] = l1_mid_i[p];
            raw[3*p+TOP] = l1_top_i[p];
        end
    end

    assign l1_d = force_i | (raw & ~mask_i);

    // Mode is registered alongside l1 so it applies to the same sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            l1_q   <= '0;
            mode_q <= MODE_ANY;
        end else begin
            l1_q   <= l1_d;
            mode_q <= mode_i;
        end
    end

    assign l1_flag_o = l1_q;

    for (genvar p = 0; p < NPHI; p++) begin : g_sec
        anita_l2_sector #(
            .MID_TOP_WIN (MID_TOP_WIN),
            .BOT_TOP_WIN (BOT_TOP_WIN),
            .BOT_MID_WIN (BOT_MID_WIN),
            .L2_HOLD     (L2_HOLD),
            .HOLDOFF     (HOLDOFF)
        ) u_sector (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .top_i      (l1_q[3*p+TOP]),
            .mid_i      (l1_q[3*p+MID]),
            .bot_i      (l1_q[3*p+BOT]),
            .mode_i     (mode_q),
            .l2_o       (l2_o[p]),
            .l2_flag_o  (l2_flag_o[p]),
            .l2_count_o (l2_count_o[16*p +: 16])
        );
    end

endmodule
